dmem_arbiter: RTL and testbench

- Shares the single-port, byte-strobed data memory between two requesters: port 0 (core load/store path) and port 1 (DMA/debug master).
- Each cycle it grants at most one access. Grants are round-robin, with a bounded lock so port 1 can issue back-to-back bursts.
- It drives the memory's write-enable, address, write-data and byte-strobe inputs. It returns the memory's combinational read data to the winner as a registered response one cycle later.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port byte-strobed data memory, with a bounded port-1 lock.
// Latency: grant in the request cycle, read data registered one cycle after the grant.
// Backpressure: a requester holds req until its gnt; at most one access per cycle.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 4,
    parameter int unsigned AW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    input  logic          m1_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rd
);
    localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

    logic          last_q, last_d;
    logic [3:0]    lock_cnt_q, lock_cnt_d;
    logic          r_pend_q, r_pend_d;
    logic          r_port_q, r_port_d;
    logic [31:0]   m0_rdata_q, m1_rdata_q;
    logic [AW-1:0] addr_q;
    logic          gnt0, gnt1, lock_act;

    // Grants are forced low while reset is asserted so no write can slip through.
    always_comb begin
        lock_act = last_q && m1_lock && (lock_cnt_q < MAX_LOCK_C);
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (rst) begin
            if (m0_req && m1_req) begin
                if (lock_act || !last_q) gnt1 = 1'b1;
                else                     gnt0 = 1'b1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt0) begin
            last_d     = 1'b0;
            lock_cnt_d = 4'd0;
        end else if (gnt1) begin
            last_d = 1'b1;
            if (!m1_lock)
                lock_cnt_d = 4'd0;
            else if (m0_req && (lock_cnt_q < MAX_LOCK_C))
                lock_cnt_d = lock_cnt_q + 4'd1;
        end
        r_pend_d = (gnt0 && !m0_we) || (gnt1 && !m1_we);
        r_port_d = gnt1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wstrb = 4'd0;
        mem_wd    = 32'd0;
        mem_a     = rst ? addr_q : '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_wstrb = m0_wstrb;
            mem_wd    = m0_wdata;
            mem_a     = m0_addr;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_wstrb = m1_wstrb;
            mem_wd    = m1_wdata;
            mem_a     = m1_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= 1'b1;
            lock_cnt_q <= 4'd0;
            r_pend_q   <= 1'b0;
            r_port_q   <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            addr_q     <= '0;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            r_pend_q   <= r_pend_d;
            r_port_q   <= r_port_d;
            if (gnt0 || gnt1) addr_q <= mem_a;
            if (gnt0 && !m0_we) m0_rdata_q <= mem_rd;
            if (gnt1 && !m1_we) m1_rdata_q <= mem_rd;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = r_pend_q && !r_port_q;
    assign m1_rvalid = r_pend_q && r_port_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a small byte-strobed memory and a
// scoreboard monitor checking grants and read responses.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [3:0]  mem_wstrb;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rd_t;

    logic [1:0] gnt_q [$];
    rd_t        rd_q  [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    dmem_arbiter #(.MAX_LOCK(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wstrb(mem_wstrb), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 64 words, combinational read, byte-strobed write at the edge.
    logic [31:0] mem [0:63];
    logic        loaded = 1'b0;
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[7]  <= 32'h0000_0020;
            mem[40] <= 32'h0000_0002;
            loaded  <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (gnt_q.size() > 0) begin
            logic [1:0] eg;
            eg = gnt_q.pop_front();
            chk("gnt", {62'd0, m1_gnt, m0_gnt}, {62'd0, eg});
        end
        if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
            chk("rvalid_missing", 64'(rd_q[0].due), 64'(cyc));
            void'(rd_q.pop_front());
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rd_q.size() == 0) begin
                chk("rvalid_unexpected", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
            end else begin
                rd_t x;
                x = rd_q.pop_front();
                chk("rvalid_port", {62'd0, m1_rvalid, m0_rvalid}, x.port ? 64'd2 : 64'd1);
                chk("rdata", {32'd0, x.port ? m1_rdata : m0_rdata}, {32'd0, x.data});
                chk("rlatency", 64'(cyc), 64'(x.due));
            end
        end
    end

    // Drive one cycle of requests and queue the expected grant (and read response).
    task automatic tick(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic [3:0] s0,
                        input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] s1,
                        input logic lk, input logic [1:0] eg,
                        input logic erd, input logic [31:0] edat);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        m1_lock = lk;
        gnt_q.push_back(eg);
        if (erd) rd_q.push_back('{port: eg[1], data: edat, due: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {59'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we}, 64'd0);
        chk({tag, "_mem_a"}, {32'd0, mem_a}, 64'd0);
        chk({tag, "_mem_wd"}, {32'd0, mem_wd}, 64'd0);
        chk({tag, "_mem_wstrb"}, {60'd0, mem_wstrb}, 64'd0);
        chk({tag, "_rdata"}, {m1_rdata, m0_rdata}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1C; m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40; m1_wdata = '0; m1_wstrb = '0;
        m1_lock = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        idle();

        // Uncontested read: same-cycle grant, data next cycle.
        tick(1'b1, 1'b0, 32'h1C, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2'b01, 1'b1, 32'h20);
        idle();

        // Round robin without lock; port 1 goes first alone so alternation starts at port 0.
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h0C, '0, '0, 1'b0, 2'b10, 1'b1, 32'h1000_0003);
        for (int i = 0; i < 4; i++) begin
            logic even;
            even = (i % 2) == 0;
            tick(1'b1, 1'b0, 32'(4 * (i + 1)), '0, '0,
                 1'b1, (i == 3), 32'(4 * (i + 10)), '0, '0, 1'b0,
                 even ? 2'b01 : 2'b10, even || (i != 3),
                 even ? 32'h1000_0000 + 32'(i + 1) : 32'h1000_0000 + 32'(i + 10));
        end

        // Lock: port 1 holds four contested beats, then port 0 is forced in.
        tick(1'b1, 1'b0, 32'h10, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2'b01, 1'b1, 32'h1000_0004);
        for (int k = 0; k < 10; k++) begin
            logic p0;
            p0 = (k == 4) || (k == 9);
            tick(1'b1, 1'b0, 32'h10, '0, '0, 1'b1, 1'b0, 32'h14, '0, '0, 1'b1,
                 p0 ? 2'b01 : 2'b10, 1'b1, p0 ? 32'h1000_0004 : 32'h1000_0005);
        end

        // Partial-strobe write then readback.
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 32'hA0, 32'hAABB_CCDD, 4'b0101, 1'b0, 2'b10, 1'b0, '0);
        tick(1'b1, 1'b0, 32'hA0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2'b01, 1'b1, 32'h00BB_00DD);

        // Same-address contention: port 0 write wins, port 1 reads it on the next cycle.
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h0C, '0, '0, 1'b0, 2'b10, 1'b1, 32'h1000_0003);
        tick(1'b1, 1'b1, 32'h40, 32'h1111_1111, 4'hF, 1'b1, 1'b0, 32'h40, '0, '0, 1'b0, 2'b01, 1'b0, '0);
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h40, '0, '0, 1'b0, 2'b10, 1'b1, 32'h1111_1111);
        idle();

        // Reset in the cycle after a read grant cancels the response.
        tick(1'b1, 1'b0, 32'h1C, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2'b01, 1'b0, '0);
        chk("pre_reset_rvalid", {63'd0, m0_rvalid}, 64'd1);
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1C; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset_hold");
        rst = 1'b1;
        tick(1'b1, 1'b0, 32'h1C, '0, '0, 1'b1, 1'b0, 32'h40, '0, '0, 1'b0, 2'b01, 1'b1, 32'h20);
        idle();
        idle();

        chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
